// File: rtl/wb_regfile.sv
// wb_regfile: writeback end of the MEM->WB interface.
// The MEM/WB pipeline register captures the MEM stage's (wd, wreg, wdata) triple;
// one cycle later the held entry commits to a 2**ADDR_W entry register file.
// Two combinational read ports serve ID; MEM/WB contents are exposed for forwarding.
// Optional build macro: WB_BYPASS_EN -- when defined, reads of the register that
// MEM/WB is about to write return the pending MEM/WB data.
module wb_regfile #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 64,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic [ADDR_W-1:0] wd_i,
    input  logic              wreg_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr1_i,
    input  logic [ADDR_W-1:0] raddr2_i,
    output logic [DATA_W-1:0] rdata1_o,
    output logic [DATA_W-1:0] rdata2_o,
    output logic [ADDR_W-1:0] wb_wd_o,
    output logic              wb_wreg_o,
    output logic [DATA_W-1:0] wb_wdata_o,
    output logic [CNT_W-1:0]  commit_cnt_o
);

    localparam int NREGS = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_reg [NREGS];
    logic [ADDR_W-1:0] wb_wd_reg;
    logic              wb_wreg_reg;
    logic [DATA_W-1:0] wb_wdata_reg;
    logic [CNT_W-1:0]  commit_cnt_reg;
    logic              commit_en;

    logic [ADDR_W-1:0] raddr_arr [2];
    logic [DATA_W-1:0] rdata_arr [2];

    // A held entry commits only when the pipe is moving and it targets a real register
    assign commit_en = wb_wreg_reg & ~stall_i & (wb_wd_reg != '0);

    // MEM/WB pipeline register: flush beats stall, stall holds, otherwise capture
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wb_wd_reg    <= '0;
            wb_wreg_reg  <= 1'b0;
            wb_wdata_reg <= '0;
        end else if (flush_i) begin
            wb_wd_reg    <= '0;
            wb_wreg_reg  <= 1'b0;
            wb_wdata_reg <= '0;
        end else if (!stall_i) begin
            wb_wd_reg    <= wd_i;
            wb_wreg_reg  <= wreg_i;
            wb_wdata_reg <= wdata_i;
        end
    end

    // Register file write; reset wins over a commit presented in the same cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_reg[i] <= '0;
            end
        end else if (commit_en) begin
            regs_reg[wb_wd_reg] <= wb_wdata_reg;
        end
    end

    // Count effective register writes; wraps silently
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            commit_cnt_reg <= '0;
        end else if (commit_en) begin
            commit_cnt_reg <= commit_cnt_reg + 1'b1;
        end
    end

    // Read one port: x0 is hard-wired to zero, optionally bypassing the pending write
    function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] addr);
        logic [DATA_W-1:0] val;
        val = regs_reg[addr];
`ifdef WB_BYPASS_EN
        if (wb_wreg_reg && (wb_wd_reg == addr)) begin
            val = wb_wdata_reg;
        end
`endif
        if (addr == '0) begin
            val = '0;
        end
        return val;
    endfunction

    assign raddr_arr[0] = raddr1_i;
    assign raddr_arr[1] = raddr2_i;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_rport
            assign rdata_arr[gi] = read_port(raddr_arr[gi]);
        end
    endgenerate

    assign rdata1_o     = rdata_arr[0];
    assign rdata2_o     = rdata_arr[1];
    assign wb_wd_o      = wb_wd_reg;
    assign wb_wreg_o    = wb_wreg_reg;
    assign wb_wdata_o   = wb_wdata_reg;
    assign commit_cnt_o = commit_cnt_reg;

endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: randomized and directed stimulus for wb_regfile, checked against a
// behavioural model of the writeback rules. The counter is built 4 bits wide so
// wrap-around is reached in a short run.
module tb_wb_regfile;

    localparam int AW = 5;
    localparam int DW = 64;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          stall_i;
    logic          flush_i;
    logic [AW-1:0] wd_i;
    logic          wreg_i;
    logic [DW-1:0] wdata_i;
    logic [AW-1:0] raddr1_i;
    logic [AW-1:0] raddr2_i;
    logic [DW-1:0] rdata1_o;
    logic [DW-1:0] rdata2_o;
    logic [AW-1:0] wb_wd_o;
    logic          wb_wreg_o;
    logic [DW-1:0] wb_wdata_o;
    logic [CW-1:0] commit_cnt_o;

    wb_regfile #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall_i      (stall_i),
        .flush_i      (flush_i),
        .wd_i         (wd_i),
        .wreg_i       (wreg_i),
        .wdata_i      (wdata_i),
        .raddr1_i     (raddr1_i),
        .raddr2_i     (raddr2_i),
        .rdata1_o     (rdata1_o),
        .rdata2_o     (rdata2_o),
        .wb_wd_o      (wb_wd_o),
        .wb_wreg_o    (wb_wreg_o),
        .wb_wdata_o   (wb_wdata_o),
        .commit_cnt_o (commit_cnt_o)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: architectural register contents, the pending writeback and
    // the number of effective writes (kept as an unbounded integer).
    logic [DW-1:0] m_regs [32];
    int            m_pend_wd;
    bit            m_pend_valid;
    logic [DW-1:0] m_pend_data;
    int            m_commits;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] model_read(input int addr);
        if (addr == 0) return '0;
`ifdef WB_BYPASS_EN
        if (m_pend_valid && m_pend_wd == addr) return m_pend_data;
`endif
        return m_regs[addr];
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        m_pend_wd    = 0;
        m_pend_valid = 0;
        m_pend_data  = '0;
        m_commits    = 0;
    endfunction

    // One clock cycle: drive inputs, compare everything visible, then advance the model
    task automatic step(input string tag, input logic r, input logic st, input logic fl,
                        input logic [AW-1:0] wd, input logic wr, input logic [DW-1:0] wdat,
                        input logic [AW-1:0] a1, input logic [AW-1:0] a2);
        @(negedge clk);
        rst_n    = r;
        stall_i  = st;
        flush_i  = fl;
        wd_i     = wd;
        wreg_i   = wr;
        wdata_i  = wdat;
        raddr1_i = a1;
        raddr2_i = a2;
        #1;
        check({tag, ".wb_wd"},   DW'(wb_wd_o),      DW'(m_pend_valid ? m_pend_wd : m_pend_wd));
        check({tag, ".wb_wreg"}, DW'(wb_wreg_o),    DW'(m_pend_valid));
        check({tag, ".wb_wdata"}, wb_wdata_o,       m_pend_data);
        check({tag, ".cnt"},     DW'(commit_cnt_o), DW'(m_commits % 16));
        check({tag, ".rd1"},     rdata1_o,          model_read(int'(a1)));
        check({tag, ".rd2"},     rdata2_o,          model_read(int'(a2)));
        @(posedge clk);
        if (!r) begin
            model_reset();
        end else begin
            if (m_pend_valid && !st && m_pend_wd != 0) begin
                m_regs[m_pend_wd] = m_pend_data;
                m_commits++;
            end
            if (fl) begin
                m_pend_wd    = 0;
                m_pend_valid = 0;
                m_pend_data  = '0;
            end else if (!st) begin
                m_pend_wd    = int'(wd);
                m_pend_valid = wr;
                m_pend_data  = wdat;
            end
        end
    endtask

    task automatic idle(input string tag, input logic [AW-1:0] a1, input logic [AW-1:0] a2);
        step(tag, 1'b1, 1'b0, 1'b0, '0, 1'b0, '0, a1, a2);
    endtask

    logic [AW-1:0] rwd, ra1, ra2;
    logic [DW-1:0] rdat;

    initial begin
        rst_n = 1'b0; stall_i = 1'b0; flush_i = 1'b0; wd_i = '0; wreg_i = 1'b0;
        wdata_i = '0; raddr1_i = '0; raddr2_i = '0;
        model_reset();
        repeat (2) @(posedge clk);

        // Reset: populate some registers, reset for one cycle, everything reads 0
        for (int i = 1; i < 6; i++)
            step("t1_fill", 1'b1, 1'b0, 1'b0, AW'(i), 1'b1, DW'(64'h100 + i), AW'(i - 1), AW'(i));
        step("t1_rst", 1'b0, 1'b0, 1'b0, 5'd6, 1'b1, 64'h77, 5'd3, 5'd4);
        for (int i = 1; i < 6; i++) idle("t1_read", AW'(i), AW'(i + 5));
        check("t1_cnt_zero", DW'(commit_cnt_o), '0);

        // Write/read of DEAD_BEEF to x5, observed across N+1 and N+2
        step("t2_wr", 1'b1, 1'b0, 1'b0, 5'd5, 1'b1, 64'hDEAD_BEEF, 5'd5, 5'd5);
        idle("t2_n1", 5'd5, 5'd5);
        idle("t2_n2", 5'd5, 5'd5);
        check("t2_x5", rdata1_o, 64'hDEAD_BEEF);

        // x0 writes are discarded and never counted
        step("t3_wr", 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 64'h1, 5'd0, 5'd0);
        idle("t3_n1", 5'd0, 5'd0);
        idle("t3_n2", 5'd0, 5'd0);

        // Stall: entry held three cycles, committed once on release
        step("t4_cap", 1'b1, 1'b0, 1'b0, 5'd7, 1'b1, 64'h3, 5'd7, 5'd0);
        for (int i = 0; i < 3; i++) step("t4_stall", 1'b1, 1'b1, 1'b0, 5'd8, 1'b1, 64'h99, 5'd7, 5'd8);
        step("t4_rel", 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 64'h0, 5'd7, 5'd8);
        idle("t4_after", 5'd7, 5'd8);
        check("t4_x7", rdata1_o, 64'h3);

        // Flush while stalled drops the held entry
        step("t5_cap", 1'b1, 1'b0, 1'b0, 5'd9, 1'b1, 64'h55, 5'd9, 5'd9);
        step("t5_flush", 1'b1, 1'b1, 1'b1, 5'd10, 1'b1, 64'hAA, 5'd9, 5'd10);
        idle("t5_n1", 5'd9, 5'd10);
        idle("t5_n2", 5'd9, 5'd10);
        check("t5_x9", rdata1_o, 64'h0);

        // Counter wrap with back-to-back commits
        for (int i = 0; i < 20; i++)
            step("t6_wrap", 1'b1, 1'b0, 1'b0, AW'(1 + (i % 31)), 1'b1, DW'(i), AW'(i % 32), 5'd1);
        // Reset racing a pending commit: the reset wins
        step("t6_race", 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 64'h0, 5'd20, 5'd0);
        idle("t6_after", 5'd20, 5'd21);
        check("t6_x20", rdata1_o, 64'h0);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            rwd  = AW'($urandom_range(0, 31));
            rdat = {$urandom, $urandom};
            ra1  = ($urandom_range(0, 1) == 1) ? wb_wd_o : AW'($urandom_range(0, 31));
            ra2  = ($urandom_range(0, 3) == 0) ? ra1 : AW'($urandom_range(0, 31));
            step("rnd", ($urandom_range(0, 199) != 0), ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 9) == 0), rwd, ($urandom_range(0, 3) != 0), rdat, ra1, ra2);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
